// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation sequencer.
// Walks the 4-bit round index from the mode's start round up to LAST_ROUND.
// It also drives the state-register load enable and the input/feedback mux
// select, and reports busy, a one-cycle done pulse and a one-cycle error
// pulse for a reserved mode.
module ascon_perm_ctrl #(
  parameter int ROUND_W    = 4,
  parameter int LAST_ROUND = 11
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               hold_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               en_reg_state_o,
  output logic               sel_state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Every mode finishes on LAST_ROUND, so each start round counts back from it.
  localparam logic [ROUND_W-1:0] IDX_P12  = ROUND_W'(LAST_ROUND - 11);
  localparam logic [ROUND_W-1:0] IDX_P8   = ROUND_W'(LAST_ROUND - 7);
  localparam logic [ROUND_W-1:0] IDX_P6   = ROUND_W'(LAST_ROUND - 5);
  localparam logic [ROUND_W-1:0] IDX_LAST = ROUND_W'(LAST_ROUND);

  logic [1:0]         state;
  logic [ROUND_W-1:0] cnt;
  logic               first;
  logic               err_q;
  logic [ROUND_W-1:0] start_idx;
  logic               mode_ok;

  assign mode_ok = (mode_i != 2'b11);

  // Map the round-count mode to its first round index.
  always_comb begin
    start_idx = IDX_P12;
    case (mode_i)
      2'b01:   start_idx = IDX_P8;
      2'b10:   start_idx = IDX_P6;
      default: start_idx = IDX_P12;
    endcase
  end

  // Sequencer state, round counter, first-round flag and error pulse.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      first <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        // DONE behaves like IDLE for a new start, so runs can go back-to-back.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start_i) begin
            if (mode_ok) begin
              state <= S_RUN;
              cnt   <= start_idx;
              first <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // A held cycle freezes everything. The counter stops at LAST_ROUND.
        S_RUN: begin
          if (!hold_i) begin
            first <= 1'b0;
            if (cnt == IDX_LAST) state <= S_DONE;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The load enable must drop in the same cycle as hold_i so that the state
  // register does not absorb a round that the counter has not advanced past.
  // It is therefore the only output that looks at an input.
  assign en_reg_state_o = (state == S_RUN) && !hold_i;
  assign sel_state_o    = (state == S_RUN) && first;
  assign busy_o         = (state == S_RUN);
  assign done_o         = (state == S_DONE);
  assign err_o          = err_q;
  assign round_o        = (state == S_IDLE) ? '0 : cnt;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: directed and randomized permutation runs.
// Each run is checked cycle by cycle against an expected trace. The trace is
// built from the round-count rules: start round, optional hold burst, done.
module tb_ascon_perm_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       start;
  logic [1:0] mode;
  logic       hold;
  logic [3:0] round;
  logic       en, sel, busy, done, err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int r; bit en; bit sel; bit busy; bit done; bit hold;
  } cyc_t;

  ascon_perm_ctrl #(.ROUND_W(4), .LAST_ROUND(11)) dut (
    .clock_i(clk), .resetb_i(rstb), .start_i(start), .mode_i(mode),
    .hold_i(hold), .round_o(round), .en_reg_state_o(en),
    .sel_state_o(sel), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int r, input bit e, input bit s,
                         input bit b, input bit d, input bit er);
    chk({tag, ".round"}, int'(round), r);
    chk({tag, ".en"},    int'(en),    int'(e));
    chk({tag, ".sel"},   int'(sel),   int'(s));
    chk({tag, ".busy"},  int'(busy),  int'(b));
    chk({tag, ".done"},  int'(done),  int'(d));
    chk({tag, ".err"},   int'(err),   int'(er));
  endtask

  function automatic int first_round(input int m);
    return (m == 0) ? 0 : (m == 1) ? 4 : 6;
  endfunction

  // Run one permutation. The caller's position is #1 after a rising edge.
  // pre_started: the start was already accepted (back-to-back).
  // hpos/hlen: hold for hlen cycles while round hpos is showing.
  // poke_idx: pulse start_i with p6 on that trace cycle (must be ignored).
  // chain_mode: >=0 requests a new start during the DONE cycle.
  task automatic run_perm(input string tag, input int m, input int hpos,
                          input int hlen, input bit pre_started,
                          input int poke_idx, input int chain_mode);
    cyc_t q[$];
    cyc_t c;
    int s = first_round(m);
    if (!pre_started) begin
      start = 1'b1; mode = 2'(m);
      @(posedge clk); #1;
      start = 1'b0; mode = 2'b11;
    end
    for (int r = s; r <= 11; r++) begin
      int nh = (r == hpos) ? hlen : 0;
      for (int k = 0; k <= nh; k++) begin
        c.r = r; c.hold = (k < nh); c.en = !c.hold; c.sel = (r == s);
        c.busy = 1'b1; c.done = 1'b0;
        q.push_back(c);
      end
    end
    c.r = 11; c.hold = 1'b0; c.en = 1'b0; c.sel = 1'b0; c.busy = 1'b0; c.done = 1'b1;
    q.push_back(c);
    for (int i = 0; i < q.size(); i++) begin
      hold  = q[i].hold;
      start = 1'b0;
      if (i == poke_idx) begin start = 1'b1; mode = 2'b10; end
      if (i == q.size() - 1 && chain_mode >= 0) begin
        start = 1'b1; mode = 2'(chain_mode);
      end
      @(negedge clk);
      chk_all($sformatf("%s.c%0d", tag, i), q[i].r, q[i].en, q[i].sel,
              q[i].busy, q[i].done, 1'b0);
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0;
    if (chain_mode < 0) begin
      @(negedge clk);
      chk_all({tag, ".idle"}, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; mode = 2'b00; hold = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;

    // Plain runs of every mode.
    run_perm("p12", 0, -1, 0, 1'b0, -1, -1);
    run_perm("p6",  2, -1, 0, 1'b0, -1, -1);
    run_perm("p8",  1, -1, 0, 1'b0, -1, -1);
    // p6 with a 2-cycle hold at round 8.
    run_perm("p6hold", 2, 8, 2, 1'b0, -1, -1);
    // Hold during the first round keeps the input select asserted.
    run_perm("p8hold0", 1, 4, 1, 1'b0, -1, -1);

    // Reserved mode is rejected with a one-cycle error pulse.
    start = 1'b1; mode = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_all("rsvd", 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("rsvd.after", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // A start pulse in the middle of p12 must not disturb the sequence.
    run_perm("p12poke", 0, -1, 0, 1'b0, 5, -1);

    // Back-to-back: a start during DONE goes straight to round 6 of p6.
    run_perm("b2b.a", 0, -1, 0, 1'b0, -1, 2);
    run_perm("b2b.b", 2, -1, 0, 1'b1, -1, -1);

    // Asynchronous reset at round 5 of p12 clears outputs with no done.
    start = 1'b1; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("arst.pre.round", int'(round), 5);
    #2 rstb = 1'b0;
    #1;
    chk_all("arst.now", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("arst.held", 0, 0, 0, 0, 0, 0);
    rstb = 1'b1;
    @(posedge clk); #1;
    run_perm("arst.p8", 1, -1, 0, 1'b0, -1, -1);

    // Randomized modes and hold bursts.
    for (int n = 0; n < 8; n++) begin
      int m  = $urandom_range(0, 2);
      int s  = first_round(m);
      int hp = s + $urandom_range(0, 11 - s);
      int hl = $urandom_range(0, 3);
      run_perm($sformatf("rnd%0d", n), m, hp, hl, 1'b0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
